ucode_sequencer: RTL and testbench
==================================

// Module: ucode_sequencer
// PURPOSE
//  Next-generation control block. It steps a T-state counter, forms the microcode ROM address {opcode, tstate},
//  samples the 16-bit microinstruction returned by the ROM and decodes it into registered, one-hot control strobes.
//  Sits between the IR/microcode ROM and the datapath. Microinstruction bit layout is unchanged (EO bit 15,
//  bus_out/ALU 14:12, RT/NY 11, P+/F 10, NO 9, bus_in 8:6, JC/JZ/JGT/JLT 5:2).
// PARAMETERS
//  OPW   8  opcode width (ROM address high part)
//  TSW   3  T-state counter width (ROM address low part)
//  NT    8  T-states per instruction, 2..2**TSW; counter wraps NT-1 -> 0
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  reset_bar  in   1      asynchronous, active-low reset
//  opcode     in   OPW    current IR opcode, stable while tstate>=2
//  uinstr     in   16     ROM data for uaddr, combinational, valid same cycle
//  stall      in   1      hold: freeze tstate and hold outputs
//  uaddr      out  OPW+TSW {opcode, tstate}, combinational from tstate
//  tstate     out  TSW    current T-state
//  eo         out  1      ALU drives bus (registered)
//  out_en     out  8      one-hot bus_out strobe, only when !eo; bit k = code k
//  in_en      out  8      one-hot bus_in strobe; bit 0 never asserted (code 0 = none)
//  alu_flags  out  6      uinstr[14:9] registered; meaningful only when eo
//  rt         out  1      !eo && uinstr[11], registered
//  pp         out  1      !eo && uinstr[10], registered
//  jmp        out  4      {JC,JZ,JGT,JLT} = uinstr[5:2], registered
// BEHAVIOUR
//  - Reset (reset_bar low, any time): tstate=0; eo=0, out_en=0, in_en=0, alu_flags=0, rt=0, pp=0, jmp=0.
//    Output is an idle NOP, not the decode of word 0. Release is synchronous to the next clk edge.
//  - Pipeline: uaddr(n) -> uinstr(n) sampled at end of cycle n -> strobes valid for all of cycle n+1.
//    Latency is 1 cycle. The first cycle after reset shows NOP.
//  - Decode of a sampled word w: eo = !w[15].
//    out_en = eo ? 0 : (1 << w[14:12]); in_en = (w[8:6]==0) ? 0 : (1 << w[8:6]).
//    Exactly one out_en bit is high when !eo; at most one in_en bit is high.
//  - Next tstate (no stall): 0 if raw uinstr RT (uinstr[15] && uinstr[11]); else 0 if tstate==NT-1; else tstate+1.
//    RT is evaluated on the unregistered word, so the following fetch starts with no dead cycle.
//  - stall high: tstate and all registered outputs hold. stall and reset together: reset wins.
//  - RT in tstate NT-1: tstate goes to 0, a single wrap with no double count.
//  - An opcode change mid-instruction is not checked; the source guarantees stability for tstate>=2.
//  - NT is checked at elaboration: NT<2 or NT>2**TSW is an error.
// CONFIGURATION
//  UCODE_WAIT_EN defined:
//   - Adds input dev_ready (1).
//   - While the registered strobe out_en[6] (DO) or in_en[6] (DI) is high and dev_ready is low, behaviour is
//     identical to stall. The strobe stays asserted until dev_ready rises; it then completes in that cycle.
//  UCODE_WAIT_EN undefined: there is no dev_ready port and DO/DI always complete in one cycle.
// TESTING
//  1 Reset: pulse reset_bar low mid-count (tstate=5) -> tstate=0 asynchronously and all strobes 0.
//    The first post-reset cycle is NOP.
//  2 Fetch: opcode=8'h00, ROM T0=16'h8040 (PO,AI), T1=16'hB480 (MO,II,P+) -> cycle1 out_en=8'h01 in_en=8'h02;
//    cycle2 out_en=8'h08 in_en=8'h04 pp=1.
//  3 Wrap: NT=8, no RT -> uaddr low bits 0..7,0; tstate never reaches 8.
//  4 RT: uinstr=16'h8800 at tstate=3 -> next tstate=0; rt=1 in the following cycle; no dead cycle.
//  5 ALU word 16'h7E40 -> eo=1, out_en=0, alu_flags=6'h3F, in_en=8'h02, rt=0, pp=0.
//  6 stall 3 cycles at tstate=2 -> tstate and outputs frozen, then resume at 3.
//    With UCODE_WAIT_EN: DO word plus dev_ready low 2 cycles -> out_en[6] held 3 cycles.

Source files
------------

// File: rtl/ucode_sequencer_if.sv
// Bus between the microcode sequencer (master) and the IR/ROM/datapath side (slave).
// Optional UCODE_WAIT_EN adds the dev_ready handshake for DO/DI transfers.
interface ucode_sequencer_if #(
  parameter int OPW = 8,
  parameter int TSW = 3
);
  logic [OPW-1:0]     opcode;
  logic [15:0]        uinstr;
  logic               stall;
`ifdef UCODE_WAIT_EN
  logic               dev_ready;
`endif
  logic [OPW+TSW-1:0] uaddr;
  logic [TSW-1:0]     tstate;
  logic               eo;
  logic [7:0]         out_en;
  logic [7:0]         in_en;
  logic [5:0]         alu_flags;
  logic               rt;
  logic               pp;
  logic [3:0]         jmp;

`ifdef UCODE_WAIT_EN
  modport master (
    input  opcode, uinstr, stall, dev_ready,
    output uaddr, tstate, eo, out_en, in_en, alu_flags, rt, pp, jmp
  );
  modport slave (
    output opcode, uinstr, stall, dev_ready,
    input  uaddr, tstate, eo, out_en, in_en, alu_flags, rt, pp, jmp
  );
`else
  modport master (
    input  opcode, uinstr, stall,
    output uaddr, tstate, eo, out_en, in_en, alu_flags, rt, pp, jmp
  );
  modport slave (
    output opcode, uinstr, stall,
    input  uaddr, tstate, eo, out_en, in_en, alu_flags, rt, pp, jmp
  );
`endif
endinterface

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: T-state counter, ROM address {opcode,tstate}, registered one-hot control decode.
// Optional feature macro UCODE_WAIT_EN: DO/DI strobes wait for dev_ready.
module ucode_sequencer #(
  parameter int OPW = 8,
  parameter int TSW = 3,
  parameter int NT  = 8
) (
  input  logic             clk,
  input  logic             reset_bar,
  ucode_sequencer_if.master bus
);

  localparam logic [TSW-1:0] TS_LAST = TSW'(NT - 1);
  localparam logic [TSW-1:0] TS_ONE  = TSW'(1);

  if (NT < 2 || NT > (1 << TSW)) begin : g_nt_check
    $error("ucode_sequencer: NT must lie in 2..2**TSW");
  end

  function automatic logic [7:0] onehot8(input logic [2:0] code);
    return 8'd1 << code;
  endfunction

  logic [TSW-1:0] ts_q;
  logic [TSW-1:0] ts_d;
  logic           hold;
  logic           raw_rt;

  logic           eo_d;
  logic [7:0]     out_en_d;
  logic [7:0]     in_en_d;
  logic [5:0]     alu_d;
  logic           rt_d;
  logic           pp_d;
  logic [3:0]     jmp_d;

  logic           eo_p1;
  logic [7:0]     out_en_p1;
  logic [7:0]     in_en_p1;
  logic [5:0]     alu_p1;
  logic           rt_p1;
  logic           pp_p1;
  logic [3:0]     jmp_p1;

  logic [1:0]     unused_bits;
  assign unused_bits = bus.uinstr[1:0];

  // A pending DO/DI strobe behaves exactly like stall until the device is ready.
`ifdef UCODE_WAIT_EN
  assign hold = bus.stall || ((out_en_p1[6] || in_en_p1[6]) && !bus.dev_ready);
`else
  assign hold = bus.stall;
`endif

  assign raw_rt = bus.uinstr[15] && bus.uinstr[11];

  // State register
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  // Next-state: RT on the raw word restarts the fetch without a dead cycle
  always_comb begin
    ts_d = ts_q;
    if (!hold) begin
      if (raw_rt || ts_q == TS_LAST) begin
        ts_d = '0;
      end else begin
        ts_d = ts_q + TS_ONE;
      end
    end
  end

  // Output comb: address and decode of the current ROM word
  always_comb begin
    eo_d     = ~bus.uinstr[15];
    out_en_d = bus.uinstr[15] ? onehot8(bus.uinstr[14:12]) : 8'd0;
    in_en_d  = (bus.uinstr[8:6] == 3'd0) ? 8'd0 : onehot8(bus.uinstr[8:6]);
    alu_d    = bus.uinstr[14:9];
    rt_d     = raw_rt;
    pp_d     = bus.uinstr[15] && bus.uinstr[10];
    jmp_d    = bus.uinstr[5:2];
  end

  // Stage p1: strobes registered for the whole following cycle
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      eo_p1     <= 1'b0;
      out_en_p1 <= '0;
      in_en_p1  <= '0;
      alu_p1    <= '0;
      rt_p1     <= 1'b0;
      pp_p1     <= 1'b0;
      jmp_p1    <= '0;
    end else if (!hold) begin
      eo_p1     <= eo_d;
      out_en_p1 <= out_en_d;
      in_en_p1  <= in_en_d;
      alu_p1    <= alu_d;
      rt_p1     <= rt_d;
      pp_p1     <= pp_d;
      jmp_p1    <= jmp_d;
    end
  end

  assign bus.uaddr     = {bus.opcode, ts_q};
  assign bus.tstate    = ts_q;
  assign bus.eo        = eo_p1;
  assign bus.out_en    = out_en_p1;
  assign bus.in_en     = in_en_p1;
  assign bus.alu_flags = alu_p1;
  assign bus.rt        = rt_p1;
  assign bus.pp        = pp_p1;
  assign bus.jmp       = jmp_p1;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer: directed scenarios plus randomized ROM/stall against a reference model.
module tb_ucode_sequencer;
  localparam int OPW = 8;
  localparam int TSW = 3;
  localparam int NT  = 8;

  logic clk = 1'b0;
  logic reset_bar;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ucode_sequencer_if #(.OPW(OPW), .TSW(TSW)) bus();

  ucode_sequencer #(.OPW(OPW), .TSW(TSW), .NT(NT)) dut (
    .clk       (clk),
    .reset_bar (reset_bar),
    .bus       (bus)
  );

  logic [15:0] rom [0:2047];
  assign bus.uinstr = rom[bus.uaddr];

  // Reference model state: what the outputs should show in the current cycle
  logic [2:0] m_ts;
  logic       m_eo, m_rt, m_pp;
  logic [7:0] m_out, m_in;
  logic [5:0] m_alu;
  logic [3:0] m_jmp;

  function automatic logic [31:0] dut_vec();
    return {bus.tstate, bus.eo, bus.out_en, bus.in_en, bus.alu_flags, bus.rt, bus.pp, bus.jmp};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {m_ts, m_eo, m_out, m_in, m_alu, m_rt, m_pp, m_jmp};
  endfunction

  task automatic model_clear();
    m_ts = 3'd0; m_eo = 1'b0; m_rt = 1'b0; m_pp = 1'b0;
    m_out = 8'd0; m_in = 8'd0; m_alu = 6'd0; m_jmp = 4'd0;
  endtask

  // Drive one clock, advancing the model by the architectural rules
  task automatic tick(input logic st);
    logic [15:0] w;
    logic        hold;
    bus.stall = st;
    w = rom[{bus.opcode, m_ts}];
    hold = st;
`ifdef UCODE_WAIT_EN
    hold = st || ((m_out[6] || m_in[6]) && !bus.dev_ready);
`endif
    if (!hold) begin
      m_eo  = !w[15];
      m_out = w[15] ? (8'd1 << w[14:12]) : 8'd0;
      m_in  = (w[8:6] == 3'd0) ? 8'd0 : (8'd1 << w[8:6]);
      m_alu = w[14:9];
      m_rt  = w[15] && w[11];
      m_pp  = w[15] && w[10];
      m_jmp = w[5:2];
      m_ts  = (m_rt || m_ts == 3'(NT - 1)) ? 3'd0 : m_ts + 3'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 reset_bar = 1'b0;
    @(negedge clk);
    reset_bar = 1'b1;
    model_clear();
    #1;
  endtask

  task automatic fill_op(input logic [7:0] op, input logic [15:0] w);
    for (int t = 0; t < 8; t++) rom[{op, 3'(t)}] = w;
  endtask

  task automatic test_reset();
    bus.opcode = 8'h11;
    fill_op(8'h11, 16'h8040);
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b0);
    checks++;
    if (bus.tstate !== 3'd5) begin
      errors++; $display("FAIL reset_precount tstate=%0d exp 5", bus.tstate);
    end
    #2 reset_bar = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 32'd0) begin
      errors++; $display("FAIL reset_async got=%h exp 00000000", dut_vec());
    end
    @(negedge clk);
    reset_bar = 1'b1;
    model_clear();
    #1;
    checks++;
    if (dut_vec() !== 32'd0 || bus.uaddr !== 11'h088) begin
      errors++; $display("FAIL reset_nop got=%h uaddr=%h exp 00000000 088", dut_vec(), bus.uaddr);
    end
    tick(1'b0);
    checks++;
    if (bus.tstate !== 3'd1 || bus.out_en !== 8'h01 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_first got=%h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_fetch();
    bus.opcode = 8'h00;
    fill_op(8'h00, 16'h8000);
    rom[11'h000] = 16'h8040;
    rom[11'h001] = 16'hB480;
    do_reset();
    tick(1'b0);
    checks++;
    if (bus.out_en !== 8'h01 || bus.in_en !== 8'h02 || bus.eo !== 1'b0) begin
      errors++; $display("FAIL fetch_t0 out_en=%h in_en=%h eo=%b exp 01 02 0", bus.out_en, bus.in_en, bus.eo);
    end
    tick(1'b0);
    checks++;
    if (bus.out_en !== 8'h08 || bus.in_en !== 8'h04 || bus.pp !== 1'b1 || bus.rt !== 1'b0) begin
      errors++; $display("FAIL fetch_t1 out_en=%h in_en=%h pp=%b rt=%b exp 08 04 1 0",
                         bus.out_en, bus.in_en, bus.pp, bus.rt);
    end
  endtask

  task automatic test_wrap();
    bus.opcode = 8'h5A;
    fill_op(8'h5A, 16'h9240);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.uaddr !== {8'h5A, 3'(i % 8)} || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL wrap_%0d uaddr=%h exp %h", i, bus.uaddr, {8'h5A, 3'(i % 8)});
      end
      tick(1'b0);
    end
  endtask

  task automatic test_rt();
    bus.opcode = 8'h33;
    fill_op(8'h33, 16'h8100);
    rom[{8'h33, 3'd3}] = 16'h8800;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b0);
    checks++;
    if (bus.tstate !== 3'd0 || bus.rt !== 1'b1) begin
      errors++; $display("FAIL rt_mid tstate=%0d rt=%b exp 0 1", bus.tstate, bus.rt);
    end
    tick(1'b0);
    checks++;
    if (bus.tstate !== 3'd1 || bus.rt !== 1'b0 || bus.in_en !== 8'h10) begin
      errors++; $display("FAIL rt_next tstate=%0d rt=%b in_en=%h exp 1 0 10", bus.tstate, bus.rt, bus.in_en);
    end
    bus.opcode = 8'h34;
    fill_op(8'h34, 16'h8100);
    rom[{8'h34, 3'd7}] = 16'h8800;
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b0);
    checks++;
    if (bus.tstate !== 3'd0 || bus.rt !== 1'b1) begin
      errors++; $display("FAIL rt_last tstate=%0d rt=%b exp 0 1", bus.tstate, bus.rt);
    end
    tick(1'b0);
    checks++;
    if (bus.tstate !== 3'd1) begin
      errors++; $display("FAIL rt_last_next tstate=%0d exp 1", bus.tstate);
    end
  endtask

  task automatic test_alu();
    bus.opcode = 8'h44;
    fill_op(8'h44, 16'h7E40);
    do_reset();
    tick(1'b0);
    checks++;
    if (bus.eo !== 1'b1 || bus.out_en !== 8'h00 || bus.alu_flags !== 6'h3F ||
        bus.in_en !== 8'h02 || bus.rt !== 1'b0 || bus.pp !== 1'b0) begin
      errors++; $display("FAIL alu eo=%b out_en=%h alu=%h in_en=%h rt=%b pp=%b exp 1 00 3f 02 0 0",
                         bus.eo, bus.out_en, bus.alu_flags, bus.in_en, bus.rt, bus.pp);
    end
  endtask

  task automatic test_stall();
    bus.opcode = 8'h22;
    for (int t = 0; t < 8; t++) rom[{8'h22, 3'(t)}] = 16'h8000 | 16'(t << 12) | 16'(((t % 7) + 1) << 6);
    do_reset();
    tick(1'b0);
    tick(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      checks++;
      if (bus.tstate !== 3'd2 || bus.out_en !== 8'h02 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL stall_%0d got=%h exp %h", i, dut_vec(), exp_vec());
      end
    end
    tick(1'b0);
    checks++;
    if (bus.tstate !== 3'd3 || bus.out_en !== 8'h04 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL stall_resume got=%h exp %h", dut_vec(), exp_vec());
    end
    bus.stall = 1'b1;
    #2 reset_bar = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== 32'd0) begin
      errors++; $display("FAIL stall_reset got=%h exp 00000000", dut_vec());
    end
    @(negedge clk);
    reset_bar = 1'b1;
    bus.stall = 1'b0;
    model_clear();
    #1;
  endtask

`ifdef UCODE_WAIT_EN
  task automatic test_wait();
    bus.opcode = 8'h66;
    fill_op(8'h66, 16'h8040);
    rom[{8'h66, 3'd0}] = 16'hE000;
    do_reset();
    bus.dev_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      checks++;
      if (bus.out_en !== 8'h40 || bus.tstate !== 3'd1) begin
        errors++; $display("FAIL wait_%0d out_en=%h tstate=%0d exp 40 1", i, bus.out_en, bus.tstate);
      end
    end
    bus.dev_ready = 1'b1;
    tick(1'b0);
    checks++;
    if (bus.out_en !== 8'h01 || bus.tstate !== 3'd2) begin
      errors++; $display("FAIL wait_done out_en=%h tstate=%0d exp 01 2", bus.out_en, bus.tstate);
    end
  endtask
`endif

  task automatic test_random();
    logic st;
    for (int a = 0; a < 2048; a++) rom[a] = 16'($urandom);
    bus.opcode = 8'($urandom);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_ts == 3'd0 && $urandom_range(0, 1) == 0) bus.opcode = 8'($urandom);
      st = ($urandom_range(0, 3) == 0);
`ifdef UCODE_WAIT_EN
      bus.dev_ready = ($urandom_range(0, 2) != 0);
`endif
      tick(st);
      checks++;
      if (dut_vec() !== exp_vec() || bus.uaddr !== {bus.opcode, m_ts}) begin
        errors++; $display("FAIL random_%0d got=%h uaddr=%h exp %h %h",
                           i, dut_vec(), bus.uaddr, exp_vec(), {bus.opcode, m_ts});
      end
    end
`ifdef UCODE_WAIT_EN
    bus.dev_ready = 1'b1;
`endif
    bus.stall = 1'b0;
  endtask

  initial begin
    reset_bar  = 1'b0;
    bus.stall  = 1'b0;
    bus.opcode = 8'h00;
`ifdef UCODE_WAIT_EN
    bus.dev_ready = 1'b1;
`endif
    for (int a = 0; a < 2048; a++) rom[a] = 16'h0000;
    model_clear();
    #1;
    checks++;
    if (dut_vec() !== 32'd0) begin
      errors++; $display("FAIL power_on_reset got=%h exp 00000000", dut_vec());
    end
    @(negedge clk);
    reset_bar = 1'b1;
    #1;
    test_reset();
    test_fetch();
    test_wrap();
    test_rt();
    test_alu();
    test_stall();
`ifdef UCODE_WAIT_EN
    test_wait();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
